// File: rtl/ff_pkg.sv
// rtl/ff_pkg.sv - shared types and constants for the float/fixed converters
package ff_pkg;

    typedef enum logic [1:0] {
        CLS_NORM = 2'd0,
        CLS_ZERO = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } cls_t;

    localparam logic RM_RTZ = 1'b0;
    localparam logic RM_RNE = 1'b1;

    typedef struct packed {
        logic ovf;
        logic nan;
        logic inexact;
    } ff_flags_t;

    function automatic int bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

endpackage

// File: rtl/ff_align_round.sv
// rtl/ff_align_round.sv - barrel align of a significand with guard/sticky and round-nearest-even
module ff_align_round #(
    parameter int MAN_W = 23,
    parameter int SH_W  = 10,
    parameter int MAG_W = 33
) (
    input  logic [MAN_W:0]          sig,
    input  logic signed [SH_W-1:0]  sh,
    input  logic                    rne,
    output logic [MAG_W-1:0]        mag,
    output logic                    big,
    output logic                    inexact
);

    localparam int SIG_W = MAN_W + 1;
    localparam int LW    = MAG_W + SIG_W;

    logic [LW-1:0]      lwide;
    logic [2*SIG_W-1:0] rwide;
    logic [MAG_W-1:0]   kept;
    logic               guard;
    logic               sticky;
    logic               round_up;
    int                 shi;

    always_comb begin
        lwide    = '0;
        rwide    = '0;
        kept     = '0;
        guard    = 1'b0;
        sticky   = 1'b0;
        round_up = 1'b0;
        big      = 1'b0;
        shi      = int'(sh);
        if (shi >= 0) begin
            // The leading one alone already lands past the field; low bits are all zero.
            if (shi >= MAG_W) begin
                big = 1'b1;
            end else begin
                lwide = LW'(sig) << shi;
                kept  = lwide[MAG_W-1:0];
                big   = |lwide[LW-1:MAG_W];
            end
        end else if (-shi > SIG_W) begin
            sticky = 1'b1;
        end else begin
            // Upper half keeps the integer part, lower half holds every discarded bit.
            rwide    = {sig, {SIG_W{1'b0}}} >> (-shi);
            kept     = MAG_W'(rwide[2*SIG_W-1:SIG_W]);
            guard    = rwide[SIG_W-1];
            sticky   = |rwide[SIG_W-2:0];
            round_up = rne & guard & (sticky | kept[0]);
        end
        mag     = kept + MAG_W'(round_up);
        inexact = guard | sticky;
    end

endmodule

// File: rtl/float_to_fixed_stream.sv
// rtl/float_to_fixed_stream.sv - 3-stage streaming float to signed fixed-point converter
module float_to_fixed_stream
    import ff_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int MAN_W  = 23,
    parameter int INT_W  = 16,
    parameter int FRAC_W = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     in_float,
    input  logic                     in_round,
    input  logic                     in_sat,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [INT_W-1:0]         out_int,
    output logic [FRAC_W-1:0]        out_frac,
    output logic                     out_ovf,
    output logic                     out_nan,
    output logic                     out_inexact
);

    localparam int W     = INT_W + FRAC_W;
    localparam int MAG_W = W + 1;
    localparam int SH_W  = EXP_W + 2;
    localparam int BIAS  = bias(EXP_W);
    localparam logic signed [SH_W-1:0] SH_OFF = SH_W'(BIAS - FRAC_W + MAN_W);
    localparam logic [W-1:0] MAX_P = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MIN_N = {1'b1, {(W-1){1'b0}}};

    logic en;
    assign en       = out_ready | ~out_valid;
    assign in_ready = en;

    // S1: unpack and classify
    logic             sign_in;
    logic [EXP_W-1:0] exp_in;
    logic [MAN_W-1:0] man_in;
    cls_t             cls_in;
    logic             dnz_in;

    assign {sign_in, exp_in, man_in} = in_float;

    always_comb begin
        cls_in = CLS_NORM;
        dnz_in = 1'b0;
        if (&exp_in) begin
            cls_in = (|man_in) ? CLS_NAN : CLS_INF;
        end else if (exp_in == '0) begin
            cls_in = CLS_ZERO;
            dnz_in = |man_in;
        end
    end

    logic                    s1_valid, s1_sign, s1_rnd, s1_sat, s1_inx;
    cls_t                    s1_cls;
    logic [MAN_W:0]          s1_sig;
    logic signed [SH_W-1:0]  s1_sh;

    // S2: align and round
    logic [MAG_W-1:0] ar_mag;
    logic             ar_big, ar_inx;

    ff_align_round #(
        .MAN_W (MAN_W),
        .SH_W  (SH_W),
        .MAG_W (MAG_W)
    ) u_align (
        .sig     (s1_sig),
        .sh      (s1_sh),
        .rne     (s1_rnd == RM_RNE),
        .mag     (ar_mag),
        .big     (ar_big),
        .inexact (ar_inx)
    );

    logic             s2_valid, s2_sign, s2_sat, s2_big, s2_inx;
    cls_t             s2_cls;
    logic [MAG_W-1:0] s2_mag;

    // S3: sign, range check, saturation
    logic [W-1:0] res_n;
    ff_flags_t    flg_n;
    logic         ovf_mag;

    always_comb begin
        res_n   = '0;
        flg_n   = '0;
        ovf_mag = s2_sign ? (s2_big | s2_mag[W] | (s2_mag[W-1] & (|s2_mag[W-2:0])))
                          : (s2_big | s2_mag[W] | s2_mag[W-1]);
        case (s2_cls)
            CLS_NAN: flg_n.nan = 1'b1;
            CLS_INF: begin
                res_n     = s2_sign ? MIN_N : MAX_P;
                flg_n.ovf = 1'b1;
            end
            CLS_ZERO: flg_n.inexact = s2_inx;
            default: begin
                flg_n.ovf     = ovf_mag;
                flg_n.inexact = s2_inx;
                if (ovf_mag && s2_sat) begin
                    res_n = s2_sign ? MIN_N : MAX_P;
                end else begin
                    res_n = s2_sign ? -s2_mag[W-1:0] : s2_mag[W-1:0];
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1_valid    <= 1'b0;
            s1_sign     <= 1'b0;
            s1_rnd      <= 1'b0;
            s1_sat      <= 1'b0;
            s1_inx      <= 1'b0;
            s1_cls      <= CLS_ZERO;
            s1_sig      <= '0;
            s1_sh       <= '0;
            s2_valid    <= 1'b0;
            s2_sign     <= 1'b0;
            s2_sat      <= 1'b0;
            s2_big      <= 1'b0;
            s2_inx      <= 1'b0;
            s2_cls      <= CLS_ZERO;
            s2_mag      <= '0;
            out_valid   <= 1'b0;
            out_int     <= '0;
            out_frac    <= '0;
            out_ovf     <= 1'b0;
            out_nan     <= 1'b0;
            out_inexact <= 1'b0;
        end else if (en) begin
            s1_valid    <= in_valid;
            s1_sign     <= sign_in;
            s1_rnd      <= in_round;
            s1_sat      <= in_sat;
            s1_inx      <= dnz_in;
            s1_cls      <= cls_in;
            s1_sig      <= {1'b1, man_in};
            s1_sh       <= $signed({2'b00, exp_in}) - SH_OFF;

            s2_valid    <= s1_valid;
            s2_sign     <= s1_sign;
            s2_sat      <= s1_sat;
            s2_cls      <= s1_cls;
            s2_mag      <= ar_mag;
            s2_big      <= ar_big;
            s2_inx      <= (s1_cls == CLS_NORM) ? ar_inx :
                           (s1_cls == CLS_ZERO) ? s1_inx : 1'b0;

            out_valid   <= s2_valid;
            out_int     <= res_n[W-1:FRAC_W];
            out_frac    <= res_n[FRAC_W-1:0];
            out_ovf     <= flg_n.ovf;
            out_nan     <= flg_n.nan;
            out_inexact <= flg_n.inexact;
        end
    end

endmodule

// File: tb/tb_float_to_fixed_stream.sv
// tb/tb_float_to_fixed_stream.sv - scoreboard bench for float_to_fixed_stream
module tb_float_to_fixed_stream;
    import ff_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_float = '0;
    logic        in_round = 1'b0;
    logic        in_sat = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_int, out_frac;
    logic        out_ovf, out_nan, out_inexact;

    typedef struct packed {
        logic [15:0] i;
        logic [15:0] f;
        logic        ovf;
        logic        nan;
        logic        inx;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    logic [31:0] stream_f [6] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                                  32'h40800000, 32'h40A00000, 32'h40C00000};

    always #5 clk = ~clk;

    float_to_fixed_stream #(
        .EXP_W(8), .MAN_W(23), .INT_W(16), .FRAC_W(16)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_float    (in_float),
        .in_round    (in_round),
        .in_sat      (in_sat),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_int     (out_int),
        .out_frac    (out_frac),
        .out_ovf     (out_ovf),
        .out_nan     (out_nan),
        .out_inexact (out_inexact)
    );

    function automatic exp_t ex(input logic [15:0] i, input logic [15:0] f,
                                input logic o, input logic n, input logic x);
        return {i, f, o, n, x};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s got=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every word the DUT hands over must match the head of the scoreboard.
    always @(negedge clk) begin : monitor
        exp_t got;
        exp_t req;
        if (out_valid && out_ready) begin
            got = {out_int, out_frac, out_ovf, out_nan, out_inexact};
            n_vec++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_output got=%h required=none", got);
            end else begin
                req = sb_q.pop_front();
                if (got !== req) begin
                    n_err++;
                    $display("FAIL out_word got int=%h frac=%h ovf=%b nan=%b inx=%b required int=%h frac=%h ovf=%b nan=%b inx=%b",
                             got.i, got.f, got.ovf, got.nan, got.inx,
                             req.i, req.f, req.ovf, req.nan, req.inx);
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the word was accepted.
    task automatic send(input logic [31:0] f, input logic rnd, input logic sat, input exp_t e);
        int guard = 0;
        in_valid = 1'b1;
        in_float = f;
        in_round = rnd;
        in_sat   = sat;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            guard++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout got=in_ready_low required=in_ready_high");
        end else begin
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (sb_q.size() != 0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        check("drain_empty", 64'(sb_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_outputs", 64'({out_int, out_frac, out_ovf, out_nan, out_inexact}), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        rstn      = 1'b1;
        out_ready = 1'b1;

        // 1.5 with latency measurement
        send(32'h3FC00000, RM_RTZ, 1'b1, ex(16'h0001, 16'h8000, 0, 0, 0));
        @(negedge clk);
        check("latency_c1", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("latency_c2", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("latency_c3", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;

        // Directed vectors, back to back with mode changes every word
        send(32'hC0100000, RM_RTZ, 1'b1, ex(16'hFFFD, 16'hC000, 0, 0, 0));
        send(32'h47800000, RM_RTZ, 1'b1, ex(16'h7FFF, 16'hFFFF, 1, 0, 0));
        send(32'h47800000, RM_RTZ, 1'b0, ex(16'h0000, 16'h0000, 1, 0, 0));
        send(32'h37C00000, RM_RTZ, 1'b1, ex(16'h0000, 16'h0001, 0, 0, 1));
        send(32'h37C00000, RM_RNE, 1'b1, ex(16'h0000, 16'h0002, 0, 0, 1));
        send(32'h38200000, RM_RNE, 1'b1, ex(16'h0000, 16'h0002, 0, 0, 1));
        send(32'h7FC00000, RM_RNE, 1'b0, ex(16'h0000, 16'h0000, 0, 1, 0));
        send(32'hFF800000, RM_RTZ, 1'b0, ex(16'h8000, 16'h0000, 1, 0, 0));
        send(32'h00000001, RM_RNE, 1'b1, ex(16'h0000, 16'h0000, 0, 0, 1));
        send(32'h80000000, RM_RNE, 1'b1, ex(16'h0000, 16'h0000, 0, 0, 0));
        drain();

        // Back-pressure mid-stream
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    send(stream_f[k], logic'(k[0]), 1'b1, ex(16'(k + 1), 16'h0000, 0, 0, 0));
                end
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (4) @(negedge clk);
                check("bp_out_valid", 64'(out_valid), 64'd1);
                check("bp_in_ready", 64'(in_ready), 64'd0);
                repeat (2) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with a full pipe
        out_ready = 1'b0;
        send(32'h3F800000, RM_RTZ, 1'b1, ex(16'h0001, 16'h0000, 0, 0, 0));
        send(32'h40000000, RM_RTZ, 1'b1, ex(16'h0002, 16'h0000, 0, 0, 0));
        send(32'h40400000, RM_RTZ, 1'b1, ex(16'h0003, 16'h0000, 0, 0, 0));
        @(negedge clk);
        check("full_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_outputs", 64'({out_int, out_frac, out_ovf, out_nan, out_inexact}), 64'd0);
        sb_q.delete();
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;

        // Recovery after reset
        send(32'h3F000000, RM_RNE, 1'b0, ex(16'h0000, 16'h8000, 0, 0, 0));
        drain();
        repeat (4) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
